residual_sad_luma4x4: RTL and testbench



---
 rtl/residual_sad_luma4x4.sv | 162 ++++++++++++++++
 tb/tb_residual_sad_luma4x4.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/residual_sad_luma4x4.sv
// Residue and SAD generator for the eight luma 4x4 intra candidates.
// One pixel row of the latched original block is compared against all
// eight latched predictions per clock. Four row steps later the wrapped
// residue blocks, the saturated SADs and the block number are published
// together with a one-cycle valid pulse.
module residual_sad_luma4x4 #(
  parameter int SAD_MAX = 255,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0][7:0]  orig,
  input  logic [15:0][7:0]  vpred,
  input  logic [15:0][7:0]  hpred,
  input  logic [15:0][7:0]  ddlpred,
  input  logic [15:0][7:0]  ddrpred,
  input  logic [15:0][7:0]  hupred,
  input  logic [15:0][7:0]  hdpred,
  input  logic [15:0][7:0]  vlpred,
  input  logic [15:0][7:0]  vrpred,
  input  logic [12:0]       mbnumber,
  output logic              busy,
  output logic              valid,
  output logic [7:0][7:0]   sads,
  output logic [15:0][7:0]  vres,
  output logic [15:0][7:0]  hres,
  output logic [15:0][7:0]  ddlres,
  output logic [15:0][7:0]  ddrres,
  output logic [15:0][7:0]  hures,
  output logic [15:0][7:0]  hdres,
  output logic [15:0][7:0]  vlres,
  output logic [15:0][7:0]  vrres,
  output logic [12:0]       mbnumber_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef logic [15:0][7:0] blk_t;

  localparam logic [ACC_W-1:0] SAD_CAP = ACC_W'(SAD_MAX);

  state_t           state;
  logic [1:0]       row;
  blk_t             orig_q;
  blk_t             pred_q  [8];
  logic [12:0]      mb_q;
  logic [ACC_W-1:0] acc_q   [8];
  blk_t             stage_q [8];
  blk_t             res_q   [8];

  blk_t             pred_in    [8];
  blk_t             stage_next [8];
  logic [ACC_W-1:0] acc_next   [8];

  // Mode order matches the sads index: V, H, DDL, DDR, HU, HD, VL, VR.
  assign pred_in[0] = vpred;
  assign pred_in[1] = hpred;
  assign pred_in[2] = ddlpred;
  assign pred_in[3] = ddrpred;
  assign pred_in[4] = hupred;
  assign pred_in[5] = hdpred;
  assign pred_in[6] = vlpred;
  assign pred_in[7] = vrpred;

  assign vres   = res_q[0];
  assign hres   = res_q[1];
  assign ddlres = res_q[2];
  assign ddrres = res_q[3];
  assign hures  = res_q[4];
  assign hdres  = res_q[5];
  assign vlres  = res_q[6];
  assign vrres  = res_q[7];

  // Absolute difference taken at 9-bit signed width so 0-255 does not wrap.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 8'(-d) : 8'(d);
  endfunction

  // Current-row residues merged into the staging copy and row SADs added to
  // the accumulators; the registers take these on every ACCUM edge.
  always_comb begin
    for (int m = 0; m < 8; m++) begin
      // NOTE: every always_comb output gets a full default first, so a path
      // that skips an assignment cannot infer a latch.
      stage_next[m] = stage_q[m];
      acc_next[m]   = acc_q[m];
      for (int c = 0; c < 4; c++) begin
        stage_next[m][{row, c[1:0]}] = orig_q[{row, c[1:0]}] - pred_q[m][{row, c[1:0]}];
        acc_next[m] = acc_next[m]
                    + ACC_W'(abs_diff(orig_q[{row, c[1:0]}], pred_q[m][{row, c[1:0]}]));
      end
    end
  end

  // Control FSM, input latching, accumulation and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row          <= 2'd0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      orig_q       <= '0;
      mb_q         <= '0;
      sads         <= '0;
      mbnumber_out <= '0;
      // NOTE: these arrays are plain registers, not RAM, so resetting them is
      // cheap and guarantees zeroed outputs after an aborted job.
      for (int m = 0; m < 8; m++) begin
        pred_q[m]  <= '0;
        acc_q[m]   <= '0;
        stage_q[m] <= '0;
        res_q[m]   <= '0;
      end
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            orig_q <= orig;
            mb_q   <= mbnumber;
            row    <= 2'd0;
            busy   <= 1'b1;
            state  <= ACCUM;
            for (int m = 0; m < 8; m++) begin
              pred_q[m]  <= pred_in[m];
              acc_q[m]   <= '0;
              stage_q[m] <= '0;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ACCUM: begin
          row <= row + 2'd1;
          for (int m = 0; m < 8; m++) begin
            stage_q[m] <= stage_next[m];
            acc_q[m]   <= acc_next[m];
          end
          if (row == 2'd3) begin
            // Last row: publish the complete staging copy and saturated SADs.
            state        <= DONE;
            busy         <= 1'b0;
            valid        <= 1'b1;
            mbnumber_out <= mb_q;
            for (int m = 0; m < 8; m++) begin
              res_q[m] <= stage_next[m];
              sads[m]  <= (acc_next[m] > SAD_CAP) ? SAD_CAP[7:0] : acc_next[m][7:0];
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_residual_sad_luma4x4.sv
// Directed bench for residual_sad_luma4x4. Inputs are driven and outputs
// sampled on the falling edge; cycle k of a job is the half period after the
// (k-1)th rising edge following the start edge.
module tb_residual_sad_luma4x4;

  typedef logic [15:0][7:0] blk_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  blk_t            orig;
  blk_t            pred [8];
  logic [12:0]     mbnumber;
  logic            busy;
  logic            valid;
  logic [7:0][7:0] sads;
  blk_t            res [8];
  logic [12:0]     mbnumber_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  residual_sad_luma4x4 dut (
    .clk(clk), .reset(reset), .start(start), .orig(orig),
    .vpred(pred[0]), .hpred(pred[1]), .ddlpred(pred[2]), .ddrpred(pred[3]),
    .hupred(pred[4]), .hdpred(pred[5]), .vlpred(pred[6]), .vrpred(pred[7]),
    .mbnumber(mbnumber), .busy(busy), .valid(valid), .sads(sads),
    .vres(res[0]), .hres(res[1]), .ddlres(res[2]), .ddrres(res[3]),
    .hures(res[4]), .hdres(res[5]), .vlres(res[6]), .vrres(res[7]),
    .mbnumber_out(mbnumber_out)
  );

  // Orig all o; every prediction equals orig except mode m, which is all p.
  task automatic set_uniform(input logic [7:0] o, input int m, input logic [7:0] p);
    for (int i = 0; i < 16; i++) orig[i] = o;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 16; i++) pred[k][i] = (k == m) ? p : o;
  endtask

  // Pulse start for one edge; returns at the falling edge of cycle 1.
  task automatic start_job(input logic [12:0] mb);
    mbnumber = mb;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // From cycle 1, step until valid is seen or the budget runs out.
  task automatic wait_valid(output int n);
    n = 1;
    while (valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    mbnumber = 13'd77;
    set_uniform(8'd9, 0, 8'd1);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", valid); end
    total++; if (sads !== 64'd0) begin bad++; $display("FAIL reset_sads got %h exp 0", sads); end
    total++; if (mbnumber_out !== 13'd0) begin bad++; $display("FAIL reset_mb got %0d exp 0", mbnumber_out); end
    for (int m = 0; m < 8; m++) begin
      total++; if (res[m] !== '0) begin bad++; $display("FAIL reset_res[%0d] got %h exp 0", m, res[m]); end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_identity;
    for (int i = 0; i < 16; i++) orig[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) pred[k] = orig;
    start_job(13'd37);
    for (int k = 1; k <= 6; k++) begin
      total++; if (busy !== (k <= 4)) begin bad++; $display("FAIL ident_busy cycle %0d got %b exp %b", k, busy, (k <= 4)); end
      total++; if (valid !== (k == 5)) begin bad++; $display("FAIL ident_valid cycle %0d got %b exp %b", k, valid, (k == 5)); end
      if (k == 5) begin
        total++; if (sads !== 64'd0) begin bad++; $display("FAIL ident_sads got %h exp 0", sads); end
        total++; if (mbnumber_out !== 13'd37) begin bad++; $display("FAIL ident_mb got %0d exp 37", mbnumber_out); end
        for (int m = 0; m < 8; m++) begin
          total++; if (res[m] !== '0) begin bad++; $display("FAIL ident_res[%0d] got %h exp 0", m, res[m]); end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate;
    int n;
    logic [7:0] es [8];
    set_uniform(8'd200, 0, 8'd100);
    start_job(13'd1);
    wait_valid(n);
    total++; if (n !== 5) begin bad++; $display("FAIL sat_latency got %0d exp 5", n); end
    for (int m = 0; m < 8; m++) es[m] = (m == 0) ? 8'd255 : 8'd0;
    for (int m = 0; m < 8; m++) begin
      total++; if (sads[m] !== es[m]) begin bad++; $display("FAIL sat_sads[%0d] got %0d exp %0d", m, sads[m], es[m]); end
      total++; if (res[m] !== ((m == 0) ? {16{8'd100}} : '0)) begin bad++; $display("FAIL sat_res[%0d] got %h", m, res[m]); end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int n;
    set_uniform(8'd5, 1, 8'd10);
    start_job(13'd2);
    wait_valid(n);
    total++; if (n !== 5) begin bad++; $display("FAIL wrap_latency got %0d exp 5", n); end
    total++; if (res[1] !== {16{8'hFB}}) begin bad++; $display("FAIL wrap_hres_neg got %h exp all fb", res[1]); end
    total++; if (sads[1] !== 8'd80) begin bad++; $display("FAIL wrap_sad_neg got %0d exp 80", sads[1]); end
    total++; if (sads[0] !== 8'd0) begin bad++; $display("FAIL wrap_sad_v got %0d exp 0", sads[0]); end
    @(negedge clk);
    set_uniform(8'd10, 1, 8'd5);
    start_job(13'd3);
    wait_valid(n);
    total++; if (n !== 5) begin bad++; $display("FAIL wrap2_latency got %0d exp 5", n); end
    total++; if (res[1] !== {16{8'h05}}) begin bad++; $display("FAIL wrap_hres_pos got %h exp all 05", res[1]); end
    total++; if (sads[1] !== 8'd80) begin bad++; $display("FAIL wrap_sad_pos got %0d exp 80", sads[1]); end
    @(negedge clk);
  endtask

  task automatic test_distinct;
    int n;
    logic [7:0] es [8];
    blk_t er [8];
    for (int i = 0; i < 16; i++) orig[i] = 8'(i * 10 + 7);
    for (int k = 0; k < 8; k++) pred[k] = orig;
    for (int c = 0; c < 4; c++) begin
      pred[2][8 + c] = orig[8 + c] + 8'd1;
      pred[7][8 + c] = orig[8 + c] + 8'd3;
    end
    for (int m = 0; m < 8; m++) begin es[m] = 8'd0; er[m] = '0; end
    es[2] = 8'd4;
    es[7] = 8'd12;
    for (int c = 0; c < 4; c++) begin
      er[2][8 + c] = 8'hFF;
      er[7][8 + c] = 8'hFD;
    end
    start_job(13'd4);
    wait_valid(n);
    total++; if (n !== 5) begin bad++; $display("FAIL dist_latency got %0d exp 5", n); end
    for (int m = 0; m < 8; m++) begin
      total++; if (sads[m] !== es[m]) begin bad++; $display("FAIL dist_sads[%0d] got %0d exp %0d", m, sads[m], es[m]); end
      total++; if (res[m] !== er[m]) begin bad++; $display("FAIL dist_res[%0d] got %h exp %h", m, res[m], er[m]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int valids;
    set_uniform(8'd10, 1, 8'd5);
    start_job(13'd100);
    valids = 0;
    for (int k = 1; k <= 10; k++) begin
      // Cycles 2 and 3: start with different data while busy must be ignored.
      if (k == 2) begin set_uniform(8'd0, 0, 8'd50); mbnumber = 13'd999; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (valid === 1'b1) valids++;
      if (k == 5) begin
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got %b exp 1", valid); end
        total++; if (sads[1] !== 8'd80) begin bad++; $display("FAIL b2b_first_sad got %0d exp 80", sads[1]); end
        total++; if (sads[0] !== 8'd0) begin bad++; $display("FAIL b2b_first_sad_v got %0d exp 0", sads[0]); end
        total++; if (mbnumber_out !== 13'd100) begin bad++; $display("FAIL b2b_first_mb got %0d exp 100", mbnumber_out); end
        set_uniform(8'd200, 0, 8'd100);
        mbnumber = 13'd200;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (k == 9) begin
        total++; if (valids !== 1) begin bad++; $display("FAIL b2b_single_valid got %0d exp 1", valids); end
        total++; if (sads[1] !== 8'd80 || mbnumber_out !== 13'd100) begin bad++; $display("FAIL b2b_hold got sad %0d mb %0d exp 80 100", sads[1], mbnumber_out); end
      end
      if (k == 10) begin
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got %b exp 1", valid); end
        total++; if (sads[0] !== 8'd255 || sads[1] !== 8'd0) begin bad++; $display("FAIL b2b_second_sads got %0d %0d exp 255 0", sads[0], sads[1]); end
        total++; if (mbnumber_out !== 13'd200) begin bad++; $display("FAIL b2b_second_mb got %0d exp 200", mbnumber_out); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int valids;
    set_uniform(8'd10, 1, 8'd5);
    start_job(13'd55);
    @(negedge clk);           // cycle 2
    @(negedge clk);           // cycle 3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b exp 0", valid); end
    total++; if (sads !== 64'd0) begin bad++; $display("FAIL rst_mid_sads got %h exp 0", sads); end
    total++; if (mbnumber_out !== 13'd0) begin bad++; $display("FAIL rst_mid_mb got %0d exp 0", mbnumber_out); end
    total++; if (res[0] !== '0) begin bad++; $display("FAIL rst_mid_vres got %h exp 0", res[0]); end
    valids = 0;
    repeat (8) begin
      if (valid === 1'b1) valids++;
      @(negedge clk);
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL rst_mid_no_valid got %0d exp 0", valids); end
    start_job(13'd55);
    wait_valid(n);
    total++; if (n !== 5) begin bad++; $display("FAIL rst_fresh_latency got %0d exp 5", n); end
    total++; if (sads[1] !== 8'd80) begin bad++; $display("FAIL rst_fresh_sad got %0d exp 80", sads[1]); end
    total++; if (mbnumber_out !== 13'd55) begin bad++; $display("FAIL rst_fresh_mb got %0d exp 55", mbnumber_out); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mbnumber = '0;
    set_uniform(8'd0, -1, 8'd0);
    @(negedge clk);
    test_reset;
    test_identity;
    test_saturate;
    test_wrap;
    test_distinct;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
